// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the screen coordinate type.
// The scan driver, game logic and sprite renderers all use this package.
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    // Raster coordinate, wide enough for 0..799 and 0..524
    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous reset to a chosen idle value.
// The scan driver uses it to hold the timing signals back by the renderer latency.
module sig_delay
    import vga_timing_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage to its idle value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// Raster-scan timing generator and pixel output stage for a VGA display.
// Counters give the renderers their drawing position; rgb_in comes back PIPE_LAT
// clocks later. Active/hsync/vsync are delayed PIPE_LAT clocks in sig_delay and
// then pass through the same output register as the colour, so the total sync
// delay is PIPE_LAT+1 and colour and sync leave the block mutually aligned.
// The raster geometry defaults to the package values; it is overridable only so
// reduced rasters can be exercised quickly.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int PIPE_LAT  = 2,
    parameter int H_VISIBLE = H_VIS,
    parameter int H_FRONT   = H_FP,
    parameter int H_SYNC_W  = H_SYNC,
    parameter int H_BACK    = H_BP,
    parameter int V_VISIBLE = V_VIS,
    parameter int V_FRONT   = V_FP,
    parameter int V_SYNC_W  = V_SYNC,
    parameter int V_BACK    = V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rgb_in,
    output coord_t     drawingPositionX,
    output coord_t     drawingPositionY,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       frameTick
);

    localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK - 1);
    localparam coord_t H_ACT    = coord_t'(H_VISIBLE);
    localparam coord_t V_ACT    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC_W);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC_W);

    coord_t     h_count;
    coord_t     v_count;
    logic       active_raw;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] dly_q;   // {active, hs, vs} as seen PIPE_LAT clocks later

    // Raster counters: h wraps every line, v advances on the last pixel of a line
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? coord_t'(0) : v_count + coord_t'(1);
        end else begin
            h_count <= h_count + coord_t'(1);
        end
    end

    assign drawingPositionX = h_count;
    assign drawingPositionY = v_count;

    // Undelayed timing decode from the counters (syncs are active low)
    always_comb begin
        active_raw = (h_count < H_ACT) && (v_count < V_ACT);
        hs_raw     = !((h_count >= HS_START) && (h_count < HS_END));
        vs_raw     = !((v_count >= VS_START) && (v_count < VS_END));
    end

    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (3'b011)
    ) u_timing_dly (
        .clk (clk),
        .rst (rst),
        .d   ({active_raw, hs_raw, vs_raw}),
        .q   (dly_q)
    );

    // Output register: final sync stage plus colour gated by the delayed active window
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            vgaRed   <= 4'h0;
            vgaGreen <= 4'h0;
            vgaBlue  <= 4'h0;
        end else begin
            hsync <= dly_q[1];
            vsync <= dly_q[0];
            if (dly_q[2]) begin
                vgaRed   <= {4{rgb_in[2]}};
                vgaGreen <= {4{rgb_in[1]}};
                vgaBlue  <= {4{rgb_in[0]}};
            end else begin
                vgaRed   <= 4'h0;
                vgaGreen <= 4'h0;
                vgaBlue  <= 4'h0;
            end
        end
    end

    // Frame tick marks the first pixel clock of vertical blanking, undelayed
    assign frameTick = (h_count == 10'd0) && (v_count == V_ACT);

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver. Four instances: full 640x480 timing at PIPE_LAT 2, 1
// and 5, and a reduced raster (30x22 clocks) so whole frames fit in a short run.
// The reference model maps "cycles since reset" straight to raster positions
// with div/mod arithmetic and derives every output from that position.
module tb_vga_scan_driver;

    localparam int NCFG   = 4;
    localparam int N_ITER = 12000;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst [NCFG];
    logic [2:0] rgb [NCFG];
    logic [9:0] dpx [NCFG];
    logic [9:0] dpy [NCFG];
    logic       hs  [NCFG];
    logic       vs  [NCFG];
    logic       tk  [NCFG];
    logic [3:0] r   [NCFG];
    logic [3:0] g   [NCFG];
    logic [3:0] b   [NCFG];

    // Raster geometry and renderer pattern per instance
    int lat_c  [NCFG] = '{2, 1, 5, 2};
    int hvis_c [NCFG] = '{640, 640, 640, 16};
    int hfp_c  [NCFG] = '{16, 16, 16, 4};
    int hsw_c  [NCFG] = '{96, 96, 96, 6};
    int hbp_c  [NCFG] = '{48, 48, 48, 4};
    int vvis_c [NCFG] = '{480, 480, 480, 12};
    int vfp_c  [NCFG] = '{10, 10, 10, 3};
    int vsw_c  [NCFG] = '{2, 2, 2, 2};
    int vbp_c  [NCFG] = '{33, 33, 33, 5};
    int pat_c  [NCFG] = '{0, 1, 2, 2};

    vga_scan_driver #(.PIPE_LAT(2)) u0 (
        .clk(clk), .rst(rst[0]), .rgb_in(rgb[0]),
        .drawingPositionX(dpx[0]), .drawingPositionY(dpy[0]),
        .hsync(hs[0]), .vsync(vs[0]),
        .vgaRed(r[0]), .vgaGreen(g[0]), .vgaBlue(b[0]), .frameTick(tk[0])
    );

    vga_scan_driver #(.PIPE_LAT(1)) u1 (
        .clk(clk), .rst(rst[1]), .rgb_in(rgb[1]),
        .drawingPositionX(dpx[1]), .drawingPositionY(dpy[1]),
        .hsync(hs[1]), .vsync(vs[1]),
        .vgaRed(r[1]), .vgaGreen(g[1]), .vgaBlue(b[1]), .frameTick(tk[1])
    );

    vga_scan_driver #(.PIPE_LAT(5)) u2 (
        .clk(clk), .rst(rst[2]), .rgb_in(rgb[2]),
        .drawingPositionX(dpx[2]), .drawingPositionY(dpy[2]),
        .hsync(hs[2]), .vsync(vs[2]),
        .vgaRed(r[2]), .vgaGreen(g[2]), .vgaBlue(b[2]), .frameTick(tk[2])
    );

    vga_scan_driver #(
        .PIPE_LAT(2),
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC_W(6), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(3), .V_SYNC_W(2), .V_BACK(5)
    ) u3 (
        .clk(clk), .rst(rst[3]), .rgb_in(rgb[3]),
        .drawingPositionX(dpx[3]), .drawingPositionY(dpy[3]),
        .hsync(hs[3]), .vsync(vs[3]),
        .vgaRed(r[3]), .vgaGreen(g[3]), .vgaBlue(b[3]), .frameTick(tk[3])
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int h_tot(input int c);
        return hvis_c[c] + hfp_c[c] + hsw_c[c] + hbp_c[c];
    endfunction

    function automatic int v_tot(input int c);
        return vvis_c[c] + vfp_c[c] + vsw_c[c] + vbp_c[c];
    endfunction

    // Renderer colour for a raster position
    function automatic logic [2:0] render(input int c, input int h, input int v);
        int s;
        case (pat_c[c])
            0:       s = h;
            1:       s = 7;
            default: s = h * 5 + v * 3 + (h >> 2);
        endcase
        return s[2:0];
    endfunction

    // Expected {x, y, hsync, vsync, R, G, B, tick} for cycle k after reset
    function automatic logic [34:0] expect_out(input int c, input int k);
        int         h, v, j, hj, vj;
        logic       e_hs, e_vs, e_tk;
        logic [2:0] col;
        h    = k % h_tot(c);
        v    = (k / h_tot(c)) % v_tot(c);
        e_tk = (h == 0) && (v == vvis_c[c]);
        j    = k - lat_c[c] - 1;
        e_hs = 1'b1;
        e_vs = 1'b1;
        col  = 3'b000;
        if (j >= 0) begin
            hj   = j % h_tot(c);
            vj   = (j / h_tot(c)) % v_tot(c);
            e_hs = !(hj >= hvis_c[c] + hfp_c[c] && hj < hvis_c[c] + hfp_c[c] + hsw_c[c]);
            e_vs = !(vj >= vvis_c[c] + vfp_c[c] && vj < vvis_c[c] + vfp_c[c] + vsw_c[c]);
            if (hj < hvis_c[c] && vj < vvis_c[c]) col = render(c, hj, vj);
        end
        return {10'(h), 10'(v), e_hs, e_vs, {4{col[2]}}, {4{col[1]}}, {4{col[0]}}, e_tk};
    endfunction

    function automatic logic [34:0] actual_vec(input int c);
        return {dpx[c], dpy[c], hs[c], vs[c], r[c], g[c], b[c], tk[c]};
    endfunction

    int   k        [NCFG];
    bit   valid    [NCFG];
    bit   did_rst  [NCFG];
    int   rst_left [NCFG];
    int   tick1_k  = -1;
    int   tick2_k  = -1;
    int   hs_falls = 0;
    int   hs_low   = 0;
    int   vs_low   = 0;
    logic prev_hs3 = 1'b1;

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            rst[c]      = 1'b1;
            rgb[c]      = 3'($urandom_range(0, 7));
            k[c]        = 0;
            valid[c]    = 1'b0;
            did_rst[c]  = 1'b0;
            rst_left[c] = 0;
        end

        for (int n = 0; n < N_ITER; n++) begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++) begin
                // Advance the model by the edge that just happened
                if (rst[c]) begin
                    k[c]     = 0;
                    valid[c] = 1'b1;
                end else if (valid[c]) begin
                    k[c]++;
                end

                if (valid[c]) check($sformatf("cfg%0d_cycle%0d", c, k[c]), 64'(actual_vec(c)),
                                    64'(expect_out(c, k[c])));

                // Hand-computed expectations pinning the model
                if (c == 0 && n == 2)
                    check("reset_idle", {hs[0], vs[0], r[0], g[0], b[0], tk[0]}, {2'b11, 12'h000, 1'b0});
                if (c == 0 && n == 4)
                    check("release_pos", {dpx[0], dpy[0]}, {10'd0, 10'd0});
                if (c == 0 && n == 5)
                    check("first_step_pos", {dpx[0], dpy[0]}, {10'd1, 10'd0});
                if (c == 0 && !did_rst[0] && k[0] == 3)  check("lat2_px0_black", b[0], 4'h0);
                if (c == 0 && !did_rst[0] && k[0] == 4)  check("lat2_px1_blue", {r[0], b[0]}, {4'h0, 4'hF});
                if (c == 0 && !did_rst[0] && k[0] == 658) check("lat2_hs_before", hs[0], 1'b1);
                if (c == 0 && !did_rst[0] && k[0] == 659) check("lat2_hs_fall", hs[0], 1'b0);
                if (c == 0 && !did_rst[0] && k[0] == 754) check("lat2_hs_last_low", hs[0], 1'b0);
                if (c == 0 && !did_rst[0] && k[0] == 755) check("lat2_hs_rise", hs[0], 1'b1);
                if (c == 0 && did_rst[0] && rst[0])
                    check("midline_reset_flush", {hs[0], dpx[0], dpy[0]}, {1'b1, 20'd0});
                if (c == 1 && k[1] == 1)   check("lat1_before_first", r[1], 4'h0);
                if (c == 1 && k[1] == 2)   check("lat1_first_white", {r[1], g[1], b[1]}, 12'hFFF);
                if (c == 1 && k[1] == 641) check("lat1_last_visible", r[1], 4'hF);
                if (c == 1 && k[1] == 642) check("lat1_hblank_black", {r[1], g[1], b[1]}, 12'h000);
                if (c == 2 && k[2] == 661) check("lat5_hs_before", hs[2], 1'b1);
                if (c == 2 && k[2] == 662) check("lat5_hs_fall", hs[2], 1'b0);

                // Whole-frame measurements on the reduced raster
                if (c == 3 && valid[3] && !did_rst[3]) begin
                    if (tk[3] === 1'b1) begin
                        if (tick1_k < 0) tick1_k = k[3];
                        else if (tick2_k < 0) tick2_k = k[3];
                    end
                    if (k[3] >= 360 && k[3] < 1020) begin
                        if (prev_hs3 === 1'b1 && hs[3] === 1'b0) hs_falls++;
                        if (hs[3] === 1'b0) hs_low++;
                        if (vs[3] === 1'b0) vs_low++;
                    end
                    prev_hs3 = hs[3];
                end

                // Reset plan for the next edge
                if (!did_rst[c] && !rst[c] &&
                    ((c == 0 && k[c] == 2300) || (c == 3 && k[c] == 1130))) begin
                    did_rst[c]  = 1'b1;
                    rst_left[c] = 3;
                end
                rst[c] = (n < 4) || (rst_left[c] > 0);
                if (rst_left[c] > 0) rst_left[c]--;

                // Renderer: colour for the position PIPE_LAT cycles ago, junk otherwise
                if (k[c] - lat_c[c] < 0) begin
                    rgb[c] = 3'($urandom_range(0, 7));
                end else begin
                    rgb[c] = render(c, (k[c] - lat_c[c]) % h_tot(c),
                                    ((k[c] - lat_c[c]) / h_tot(c)) % v_tot(c));
                end
            end
        end

        check("small_first_tick", 64'(tick1_k), 64'd360);
        check("small_tick_interval", 64'(tick2_k - tick1_k), 64'd660);
        check("small_hs_pulses", 64'(hs_falls), 64'd22);
        check("small_hs_low_clocks", 64'(hs_low), 64'd132);
        check("small_vs_low_clocks", 64'(vs_low), 64'd60);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
